sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO; next generation of the team's FIFO block.
//   Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty,
//   overflow/underflow pulses and an optional first-word-fall-through (FWFT) read mode.
//   Sits between a producer and consumer in one clock domain; drop-in for the current FIFO.
// PARAMETERS
//   DWIDTH     8    data word width in bits (>=1)
//   DEPTH      16   number of entries; power of two, >=4
//   AFULL_TH   14   almost_full asserted when count >= AFULL_TH (1..DEPTH)
//   AEMPTY_TH  2    almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
//   FWFT       0    0 = standard registered read; 1 = first-word-fall-through
// PORTS
//   clk           in   1                  clock, all logic on rising edge
//   rst           in   1                  asynchronous reset, active-high
//   wr_en         in   1                  write request
//   din           in   DWIDTH             write data
//   rd_en         in   1                  read request (FWFT=1: acknowledge of dout)
//   dout          out  DWIDTH             read data
//   full          out  1                  count == DEPTH
//   empty         out  1                  no word available to consumer
//   almost_full   out  1                  count >= AFULL_TH
//   almost_empty  out  1                  count <= AEMPTY_TH
//   count         out  $clog2(DEPTH)+1    words stored, 0..DEPTH
//   overflow      out  1                  1-cycle pulse: write dropped
//   underflow     out  1                  1-cycle pulse: read dropped
// BEHAVIOUR
//   - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, dout=0, empty=1, full=0,
//     almost_empty=1, almost_full=0, overflow=underflow=0. Storage array not reset.
//     Reset mid-operation discards all contents immediately; pending requests ignored.
//   - wr_acc = wr_en & !full; rd_acc = rd_en & !empty. Both evaluated on pre-edge state.
//   - Full + wr_en + rd_en: read accepted, write rejected (overflow pulses), count-1.
//   - Empty + wr_en + rd_en: write accepted, read rejected (underflow pulses), count+1.
//   - Both accepted: count unchanged, both pointers advance.
//   - Pointers are $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 with no gap or duplicate.
//   - count is a register; full/almost_* are combinational from count (no extra lag).
//   - overflow/underflow registered: high for exactly the cycle after the dropped request.
//   - FWFT=0: empty = (count==0). On rd_acc, dout <= mem[rd_ptr] at that edge
//     (1-cycle latency); dout holds value when no read accepted.
//   - FWFT=1: head word prefetched into dout register; empty=0 whenever dout holds valid
//     data. First write into empty FIFO: dout valid and empty=0 the cycle after write edge.
//     rd_acc consumes dout; next word appears same edge if stored, else empty=1.
//     count includes the prefetched word; full/count semantics identical to FWFT=0.
//   - No combinational path from wr_en/rd_en to any output.
// TESTING
//   1 Reset: rst=1 mid-traffic with count=5 -> count=0, empty=1, dout=0 same cycle
//     as assertion, before next clk.
//   2 Fill: 16 writes 0x00..0x0F, DEPTH=16 -> almost_full after 14th, full after 16th;
//     17th write -> overflow=1 one cycle, count stays 16.
//   3 Drain: 16 reads after fill (FWFT=0) -> dout 0x00..0x0F in order, each 1 cycle after
//     rd_en; 17th read -> underflow=1 one cycle, dout holds 0x0F.
//   4 Wrap: 40 alternating write/read pairs of incrementing data -> data order intact
//     across 2+ pointer wraps, count oscillates 0/1, no flag glitches.
//   5 Simultaneous: at full, wr_en=rd_en=1 -> count 15, overflow=1; at empty,
//     wr_en=rd_en=1 -> count 1, underflow=1.
//   6 FWFT=1: write 0xA5 into empty -> next cycle empty=0, dout=0xA5 without rd_en;
//     rd_en=1 -> empty=1 next cycle, count=0.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Purpose : producer/consumer handshake bundle for sync_fifo_param.
// Latency : n/a (wiring only); outputs are registered or derived from registered count inside the FIFO.
// Backpressure: producer watches full/almost_full, consumer watches empty/almost_empty.
// Ports   : wr_en/din (write), rd_en/dout (read), full/empty/almost_full/almost_empty/count (status),
//           overflow/underflow (one-cycle error pulses).
// Modports: master = the agent driving requests (producer+consumer); slave = the FIFO itself.
interface sync_fifo_param_if #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              wr_en;
   logic [DWIDTH-1:0] din;
   logic              rd_en;
   logic [DWIDTH-1:0] dout;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, din, rd_en,
      input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en,
      output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Purpose : parametrised single-clock FIFO with occupancy count, almost flags, error pulses, optional FWFT.
// Latency : FWFT=0 dout valid 1 cycle after accepted rd_en; FWFT=1 head word visible 1 cycle after first write.
// Backpressure: writes while full and reads while empty are dropped and flagged by overflow/underflow.
// Ports   : clk, rst (async active-high) plus bus (sync_fifo_param_if.slave):
//           wr_en/din in, rd_en in, dout out, full/empty/almost_full/almost_empty/count out,
//           overflow/underflow out (registered, one cycle after the dropped request).
module sync_fifo_param #(
   parameter int DWIDTH    = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = 14,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0
) (
   input  logic              clk,
   input  logic              rst,
   sync_fifo_param_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

   // Storage array: deliberately not reset, pointers and count define validity.
   logic [DWIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q,    rd_ptr_d;
   logic [CW-1:0]     count_q,     count_d;
   logic [DWIDTH-1:0] dout_q,      dout_d;
   logic              dout_vld_q,  dout_vld_d;
   logic              overflow_q,  overflow_d;
   logic              underflow_q, underflow_d;

   logic              full;
   logic              empty;
   logic              wr_acc;
   logic              rd_acc;
   logic              mem_we;
   logic              load_head;
   logic              bypass;
   logic [CW-1:0]     mem_cnt;

   // Status is derived from registered state only, so no request input
   // reaches an output combinationally.
   assign full  = (count_q == DEPTH_C);
   assign empty = (FWFT != 0) ? !dout_vld_q : (count_q == '0);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      dout_d      = dout_q;
      dout_vld_d  = dout_vld_q;
      mem_we      = 1'b0;
      load_head   = 1'b0;
      bypass      = 1'b0;

      wr_acc      = bus.wr_en & !full;
      rd_acc      = bus.rd_en & !empty;

      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
      overflow_d  = bus.wr_en & full;
      underflow_d = bus.rd_en & empty;

      // In FWFT mode the prefetched head word lives in dout_q and is part of
      // count, so the array holds one word fewer than count.
      mem_cnt     = count_q - CW'(dout_vld_q);

      if (FWFT == 0) begin
         dout_vld_d = 1'b0;
         if (wr_acc) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (rd_acc) begin
            dout_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end else begin
         // Head register needs a new word when it is empty or being consumed.
         load_head = !dout_vld_q || rd_acc;
         // With nothing stored behind the head, an incoming word goes straight
         // into the head register instead of through the array.
         bypass    = load_head && (mem_cnt == '0) && wr_acc;

         if (load_head) begin
            if (mem_cnt != '0) begin
               dout_d     = mem_q[rd_ptr_q];
               rd_ptr_d   = rd_ptr_q + 1'b1;
               dout_vld_d = 1'b1;
            end else if (wr_acc) begin
               dout_d     = bus.din;
               dout_vld_d = 1'b1;
            end else begin
               // Consumed the last word: keep the stale value, flag empty.
               dout_vld_d = 1'b0;
            end
         end

         if (wr_acc && !bypass) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         dout_q      <= '0;
         dout_vld_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         dout_q      <= dout_d;
         dout_vld_q  <= dout_vld_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Array write port; requests arriving during reset are ignored.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[wr_ptr_q] <= bus.din;
      end
   end

   assign bus.dout         = dout_q;
   assign bus.count        = count_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AFULL_C);
   assign bus.almost_empty = (count_q <= AEMPTY_C);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
   logic clk;
   logic rst;

   int n_checks;
   int n_fail;

   logic [7:0] exp_q [$];
   logic [7:0] exp;

   sync_fifo_param_if #(.DWIDTH(8), .DEPTH(16)) bus0 ();
   sync_fifo_param_if #(.DWIDTH(8), .DEPTH(16)) bus1 ();

   sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   sync_fifo_param #(.DWIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.din = '0;
      bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.din = '0;
      tick(); tick();
      #2 rst = 1'b0;
      tick();
      n_checks++; if (bus0.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus0.count); end
      n_checks++; if (bus0.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus0.empty); end
      n_checks++; if (bus0.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus0.full); end
      n_checks++; if (bus0.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", bus0.almost_empty); end
      n_checks++; if (bus0.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", bus0.almost_full); end
      n_checks++; if (bus0.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bus0.dout); end
      n_checks++; if ({bus0.overflow, bus0.underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {bus0.overflow, bus0.underflow}); end
      n_checks++; if (bus1.empty !== 1'b1) begin n_fail++; $display("FAIL reset_fwft_empty: got %b expected 1", bus1.empty); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         bus0.wr_en = 1'b1; bus0.din = 8'(i);
         tick();
         exp_q.push_back(8'(i));
         n_checks++; if (bus0.count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus0.count, i + 1); end
         n_checks++; if (bus0.almost_full !== (i + 1 >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, bus0.almost_full, (i + 1 >= 14)); end
         n_checks++; if (bus0.full !== (i + 1 == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus0.full, (i + 1 == 16)); end
      end
      bus0.din = 8'h10;
      tick();
      bus0.wr_en = 1'b0;
      n_checks++; if (bus0.overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b expected 1", bus0.overflow); end
      n_checks++; if (bus0.count !== 5'd16) begin n_fail++; $display("FAIL fill_ovf_count: got %0d expected 16", bus0.count); end
      tick();
      n_checks++; if (bus0.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pulse: got %b expected 0", bus0.overflow); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 16; i++) begin
         bus0.rd_en = 1'b1;
         tick();
         exp = exp_q.pop_front();
         n_checks++; if (bus0.dout !== exp) begin n_fail++; $display("FAIL drain_dout[%0d]: got %h expected %h", i, bus0.dout, exp); end
         n_checks++; if (bus0.count !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, bus0.count, 15 - i); end
         n_checks++; if (bus0.almost_empty !== (15 - i <= 2)) begin n_fail++; $display("FAIL drain_aempty[%0d]: got %b expected %b", i, bus0.almost_empty, (15 - i <= 2)); end
         n_checks++; if (bus0.empty !== (i == 15)) begin n_fail++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, bus0.empty, (i == 15)); end
      end
      tick();
      bus0.rd_en = 1'b0;
      n_checks++; if (bus0.underflow !== 1'b1) begin n_fail++; $display("FAIL drain_underflow: got %b expected 1", bus0.underflow); end
      n_checks++; if (bus0.dout !== 8'h0F) begin n_fail++; $display("FAIL drain_hold: got %h expected 0f", bus0.dout); end
      tick();
      n_checks++; if (bus0.underflow !== 1'b0) begin n_fail++; $display("FAIL drain_udf_pulse: got %b expected 0", bus0.underflow); end
      n_checks++; if (bus0.count !== 5'd0) begin n_fail++; $display("FAIL drain_udf_count: got %0d expected 0", bus0.count); end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 40; k++) begin
         bus0.wr_en = 1'b1; bus0.rd_en = 1'b0; bus0.din = 8'(8'h20 + k);
         tick();
         exp_q.push_back(8'(8'h20 + k));
         n_checks++; if ({bus0.count, bus0.empty, bus0.full, bus0.overflow, bus0.underflow} !== {5'd1, 4'b0000}) begin
            n_fail++; $display("FAIL wrap_after_wr[%0d]: got cnt=%0d e=%b f=%b o=%b u=%b expected cnt=1 flags 0", k, bus0.count, bus0.empty, bus0.full, bus0.overflow, bus0.underflow);
         end
         bus0.wr_en = 1'b0; bus0.rd_en = 1'b1;
         tick();
         exp = exp_q.pop_front();
         n_checks++; if (bus0.dout !== exp) begin n_fail++; $display("FAIL wrap_dout[%0d]: got %h expected %h", k, bus0.dout, exp); end
         n_checks++; if ({bus0.count, bus0.empty, bus0.overflow, bus0.underflow} !== {5'd0, 3'b100}) begin
            n_fail++; $display("FAIL wrap_after_rd[%0d]: got cnt=%0d e=%b o=%b u=%b expected cnt=0 e=1", k, bus0.count, bus0.empty, bus0.overflow, bus0.underflow);
         end
      end
      bus0.rd_en = 1'b0;
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 16; i++) begin
         bus0.wr_en = 1'b1; bus0.din = 8'(8'h40 + i);
         tick();
         exp_q.push_back(8'(8'h40 + i));
      end
      bus0.rd_en = 1'b1; bus0.din = 8'h99;
      tick();
      bus0.wr_en = 1'b0;
      exp = exp_q.pop_front();
      n_checks++; if (bus0.count !== 5'd15) begin n_fail++; $display("FAIL sim_full_count: got %0d expected 15", bus0.count); end
      n_checks++; if (bus0.overflow !== 1'b1) begin n_fail++; $display("FAIL sim_full_overflow: got %b expected 1", bus0.overflow); end
      n_checks++; if (bus0.dout !== exp) begin n_fail++; $display("FAIL sim_full_dout: got %h expected %h", bus0.dout, exp); end
      for (int i = 0; i < 15; i++) begin
         tick();
         exp = exp_q.pop_front();
         n_checks++; if (bus0.dout !== exp) begin n_fail++; $display("FAIL sim_drain_dout[%0d]: got %h expected %h", i, bus0.dout, exp); end
      end
      bus0.wr_en = 1'b1; bus0.din = 8'h77;
      tick();
      bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
      exp_q.push_back(8'h77);
      n_checks++; if (bus0.count !== 5'd1) begin n_fail++; $display("FAIL sim_empty_count: got %0d expected 1", bus0.count); end
      n_checks++; if (bus0.underflow !== 1'b1) begin n_fail++; $display("FAIL sim_empty_underflow: got %b expected 1", bus0.underflow); end
      bus0.rd_en = 1'b1;
      tick();
      bus0.rd_en = 1'b0;
      exp = exp_q.pop_front();
      n_checks++; if (bus0.dout !== exp) begin n_fail++; $display("FAIL sim_empty_dout: got %h expected %h", bus0.dout, exp); end
      n_checks++; if (bus0.count !== 5'd0) begin n_fail++; $display("FAIL sim_final_count: got %0d expected 0", bus0.count); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         bus0.wr_en = 1'b1; bus0.din = 8'(8'hE0 + i);
         tick();
      end
      n_checks++; if (bus0.count !== 5'd5) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d expected 5", bus0.count); end
      #3 rst = 1'b1;
      #1;
      n_checks++; if (bus0.count !== 5'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", bus0.count); end
      n_checks++; if (bus0.empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b expected 1", bus0.empty); end
      n_checks++; if (bus0.dout !== 8'h00) begin n_fail++; $display("FAIL rstmid_dout: got %h expected 00", bus0.dout); end
      tick();
      n_checks++; if (bus0.count !== 5'd0) begin n_fail++; $display("FAIL rstmid_hold_count: got %0d expected 0", bus0.count); end
      bus0.wr_en = 1'b0;
      #2 rst = 1'b0;
      tick();
      n_checks++; if ({bus0.count, bus0.empty, bus0.almost_empty} !== {5'd0, 2'b11}) begin
         n_fail++; $display("FAIL rstmid_release: got cnt=%0d e=%b ae=%b expected cnt=0 e=1 ae=1", bus0.count, bus0.empty, bus0.almost_empty);
      end
      exp_q.delete();
   endtask

   task automatic test_fwft();
      bus1.wr_en = 1'b1; bus1.din = 8'hA5;
      tick();
      bus1.wr_en = 1'b0;
      n_checks++; if (bus1.empty !== 1'b0) begin n_fail++; $display("FAIL fwft_first_empty: got %b expected 0", bus1.empty); end
      n_checks++; if (bus1.dout !== 8'hA5) begin n_fail++; $display("FAIL fwft_first_dout: got %h expected a5", bus1.dout); end
      n_checks++; if (bus1.count !== 5'd1) begin n_fail++; $display("FAIL fwft_first_count: got %0d expected 1", bus1.count); end
      tick();
      n_checks++; if (bus1.dout !== 8'hA5) begin n_fail++; $display("FAIL fwft_hold_dout: got %h expected a5", bus1.dout); end
      bus1.rd_en = 1'b1;
      tick();
      bus1.rd_en = 1'b0;
      n_checks++; if (bus1.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_read_empty: got %b expected 1", bus1.empty); end
      n_checks++; if (bus1.count !== 5'd0) begin n_fail++; $display("FAIL fwft_read_count: got %0d expected 0", bus1.count); end
      bus1.rd_en = 1'b1;
      tick();
      bus1.rd_en = 1'b0;
      n_checks++; if (bus1.underflow !== 1'b1) begin n_fail++; $display("FAIL fwft_underflow: got %b expected 1", bus1.underflow); end

      for (int i = 0; i < 16; i++) begin
         bus1.wr_en = 1'b1; bus1.din = 8'(8'hC0 + i);
         tick();
         exp_q.push_back(8'(8'hC0 + i));
         n_checks++; if (bus1.count !== 5'(i + 1)) begin n_fail++; $display("FAIL fwft_fill_count[%0d]: got %0d expected %0d", i, bus1.count, i + 1); end
         n_checks++; if (bus1.dout !== exp_q[0]) begin n_fail++; $display("FAIL fwft_fill_head[%0d]: got %h expected %h", i, bus1.dout, exp_q[0]); end
      end
      n_checks++; if (bus1.full !== 1'b1) begin n_fail++; $display("FAIL fwft_full: got %b expected 1", bus1.full); end
      tick();
      bus1.wr_en = 1'b0;
      n_checks++; if (bus1.overflow !== 1'b1) begin n_fail++; $display("FAIL fwft_overflow: got %b expected 1", bus1.overflow); end
      for (int i = 0; i < 16; i++) begin
         n_checks++; if ({bus1.empty, bus1.dout} !== {1'b0, exp_q[0]}) begin
            n_fail++; $display("FAIL fwft_drain[%0d]: got e=%b dout=%h expected e=0 dout=%h", i, bus1.empty, bus1.dout, exp_q[0]);
         end
         bus1.rd_en = 1'b1;
         tick();
         exp = exp_q.pop_front();
      end
      bus1.rd_en = 1'b0;
      n_checks++; if ({bus1.empty, bus1.count} !== {1'b1, 5'd0}) begin
         n_fail++; $display("FAIL fwft_drained: got e=%b cnt=%0d expected e=1 cnt=0", bus1.empty, bus1.count);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      test_fwft();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
